// File: rtl/accum_readout_pkg.sv
// Shared types and widths for the accumulator frame controller and its mean scaler.
package accum_readout_pkg;

   localparam int unsigned ACC_W  = 32;
   localparam int unsigned CNT_W  = 10;
   localparam int unsigned SAMP_W = 16;
   localparam int unsigned SEQ_W  = 8;

   typedef enum logic [1:0] {
      StClear = 2'd0,
      StAccum = 2'd1,
      StWait  = 2'd2
   } state_e;

   // Number of samples in one frame, sized to the accumulator counter.
   function automatic logic [CNT_W-1:0] frame_len(input int unsigned log2_n);
      frame_len = CNT_W'(1) << log2_n;
   endfunction

endpackage

// File: rtl/accum_mean_scale.sv
// Converts a 2^LOG2_N-sample sum into a 16-bit mean, saturating when the mean
// does not fit.
module accum_mean_scale
   import accum_readout_pkg::*;
#(
   parameter int unsigned LOG2_N = 8
) (
   input  logic [ACC_W-1:0]  accum_i,
   output logic [SAMP_W-1:0] mean_o,
   output logic              sat_o
);

   logic [ACC_W-1:0] shifted;

   assign shifted = accum_i >> LOG2_N;

   // Any surviving bit above the sample width (including accum[31]) means overflow.
   always_comb begin
      sat_o  = |shifted[ACC_W-1:SAMP_W];
      mean_o = sat_o ? {SAMP_W{1'b1}} : shifted[SAMP_W-1:0];
   end

endmodule

// File: rtl/accum_readout.sv
// Frame controller for the sample accumulator: admits one frame of samples, captures
// the mean into a valid/ready output register, then clears the accumulator.
module accum_readout
   import accum_readout_pkg::*;
#(
   parameter int unsigned LOG2_N = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              enable_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic              acc_ce_o,
   output logic              acc_clear_o,
   input  logic [ACC_W-1:0]  accum_i,
   input  logic [CNT_W-1:0]  counter_i,
   output logic [SAMP_W-1:0] out_data_o,
   output logic              out_sat_o,
   output logic [SEQ_W-1:0]  out_seq_o,
   output logic              out_valid_o,
   input  logic              out_ready_i
);

   localparam logic [CNT_W-1:0] FrameLen = frame_len(LOG2_N);

   state_e            state_q, state_d;
   logic              acc_clear_q, acc_clear_d;
   logic              out_valid_q, out_valid_d;
   logic [SAMP_W-1:0] out_data_q, out_data_d;
   logic              out_sat_q, out_sat_d;
   logic [SEQ_W-1:0]  out_seq_q, out_seq_d;
   logic [SEQ_W-1:0]  load_cnt_q, load_cnt_d;

   logic              frame_done;
   logic              can_load;
   logic              load;
   logic [SAMP_W-1:0] mean;
   logic              mean_sat;

   accum_mean_scale #(
      .LOG2_N (LOG2_N)
   ) u_mean_scale (
      .accum_i (accum_i),
      .mean_o  (mean),
      .sat_o   (mean_sat)
   );

   assign frame_done = (counter_i == FrameLen);
   assign can_load   = !out_valid_q || out_ready_i;
   assign in_ready_o = (state_q == StAccum) && enable_i && !frame_done;
   assign acc_ce_o   = in_valid_i && in_ready_o;

   // A completed frame takes priority over a dropped enable so it is never lost.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      unique case (state_q)
         StClear: begin
            if (enable_i) begin
               state_d = StAccum;
            end
         end
         StAccum: begin
            if (frame_done) begin
               if (can_load) begin
                  load    = 1'b1;
                  state_d = StClear;
               end else begin
                  state_d = StWait;
               end
            end else if (!enable_i) begin
               state_d = StClear;
            end
         end
         StWait: begin
            if (can_load) begin
               load    = 1'b1;
               state_d = StClear;
            end
         end
         default: state_d = StClear;
      endcase
   end

   always_comb begin
      acc_clear_d = (state_d == StClear);
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      out_seq_d   = out_seq_q;
      load_cnt_d  = load_cnt_q;
      if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end
      // A load in the same cycle as a transfer overrides the clear above.
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = mean;
         out_sat_d   = mean_sat;
         out_seq_d   = load_cnt_q;
         load_cnt_d  = load_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StClear;
         acc_clear_q <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         out_seq_q   <= '0;
         load_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         acc_clear_q <= acc_clear_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         out_seq_q   <= out_seq_d;
         load_cnt_q  <= load_cnt_d;
      end
   end

   assign acc_clear_o = acc_clear_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_sat_o   = out_sat_q;
   assign out_seq_o   = out_seq_q;

endmodule
